// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
package if_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misal;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr, misal} entries; clear has priority over push/pop.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               valid_o,
    output logic [CW-1:0]      count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wptr_q;
    logic [PW-1:0]      rptr_q;
    logic [CW-1:0]      count_q;
    logic               do_pop;

    assign do_pop = pop_i & (count_q != '0);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: turns accepted PCs into single-outstanding imem reads and queues {pc, instr} for decode.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid_i,
    output logic            pc_ready_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_misal_o,
    input  logic            instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ;
    logic            pc_acc;
    logic            pc_misal;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // In-flight fetch holds a reserved slot so a later push can never overflow.
    assign occ        = count + CW'(state_q != IDLE);
    assign pc_ready_o = (state_q == IDLE) & (occ < CW'(DEPTH)) & ~flush_i;
    assign pc_acc     = pc_valid_i & pc_ready_o;
    assign pc_misal   = (pc_i[1:0] != 2'b00);
    assign fifo_pop   = instr_valid_o & instr_ready_i & ~flush_i;

    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        addr_d     = addr_q;
        fifo_push  = 1'b0;
        push_entry = '0;
        case (state_q)
            IDLE: begin
                if (pc_acc) begin
                    if (pc_misal) begin
                        fifo_push  = 1'b1;
                        push_entry = '{pc: pc_i, instr: NOP_INSTR, misal: 1'b1};
                    end else begin
                        addr_d  = pc_i;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // The request stays up until granted; flush only marks the response dead.
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (imem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (imem_rvalid_i) begin
                    fifo_push  = ~kill_q & ~flush_i;
                    push_entry = '{pc: addr_q, instr: imem_rdata_i, misal: 1'b0};
                    kill_d     = 1'b0;
                    state_d    = IDLE;
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            req_q   <= (state_d == REQ);
        end
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (head),
        .valid_o (instr_valid_o),
        .count_o (count)
    );

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;
    assign instr_misal_o = head.misal;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue with a req/gnt/rvalid memory responder.
module tb_if_fetch_queue;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_misal_o;
    logic        instr_ready_i;

    int n_vec = 0;
    int n_err = 0;

    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    int          gnt_stall = 0;
    int          rv_delay  = 0;
    int          stall_left;
    int          rv_wait;
    bit          pend;
    bit          req_seen;
    logic [31:0] pend_addr;
    logic [31:0] req_addr0;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .pc_ready_o    (pc_ready_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_misal_o (instr_misal_o),
        .instr_ready_i (instr_ready_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h00500093 + (a << 8);
    endfunction

    function automatic fetch_entry_t model_entry(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00) begin
            e.instr = NOP_INSTR;
            e.misal = 1'b1;
        end else begin
            e.instr = mem_data(pc);
            e.misal = 1'b0;
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_pc(input logic [31:0] pc);
        int  n = 0;
        bit  acc = 1'b0;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        do begin
            @(negedge clk);
            acc = pc_ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        pc_valid_i = 1'b0;
        check("pc_accept", 32'(acc), 32'd1);
    endtask

    // Scoreboard: push on PC acceptance, compare on pop, drop on flush/reset.
    always @(negedge clk) begin
        if (!rst_n || flush_i) begin
            exp_q.delete();
        end else begin
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'(instr_valid_o), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_pc", instr_pc_o, mon_e.pc);
                    check("pop_instr", instr_o, mon_e.instr);
                    check("pop_misal", 32'(instr_misal_o), 32'(mon_e.misal));
                end
            end
            if (pc_valid_i && pc_ready_o) begin
                exp_q.push_back(model_entry(pc_i));
            end
        end
    end

    // Memory responder; deliberately ignores rst_n so a reset leaves a stray rvalid behind.
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        pend          = 1'b0;
        req_seen      = 1'b0;
        forever begin
            @(negedge clk);
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            if (pend) begin
                if (rv_wait == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_data(pend_addr);
                    pend          = 1'b0;
                end else begin
                    rv_wait--;
                end
            end
            if (imem_req_o) begin
                if (!req_seen) begin
                    req_seen   = 1'b1;
                    stall_left = gnt_stall;
                    req_addr0  = imem_addr_o;
                end else begin
                    check("addr_stable", imem_addr_o, req_addr0);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    imem_gnt_i = 1'b1;
                    pend       = 1'b1;
                    pend_addr  = imem_addr_o;
                    rv_wait    = rv_delay;
                    req_seen   = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int req_cnt;
        rst_n         = 1'b0;
        flush_i       = 1'b0;
        pc_i          = '0;
        pc_valid_i    = 1'b0;
        instr_ready_i = 1'b0;
        #2;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_misal", 32'(instr_misal_o), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_pc_ready", 32'(pc_ready_o), 32'd1);

        // 1: minimum latency, pc 0
        instr_ready_i = 1'b1;
        send_pc(32'h0);
        @(negedge clk);
        check("t1_req_c1", 32'(imem_req_o), 32'd1);
        check("t1_addr_c1", imem_addr_o, 32'h0);
        check("t1_valid_c1", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        check("t1_req_c2", 32'(imem_req_o), 32'd0);
        check("t1_valid_c2", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        check("t1_valid_c3", 32'(instr_valid_o), 32'd1);
        check("t1_pc", instr_pc_o, 32'h0);
        check("t1_instr", instr_o, 32'h00500093);
        tick(2);

        // 2: back-to-back PCs with decode stalled
        instr_ready_i = 1'b0;
        send_pc(32'h0);
        send_pc(32'h4);
        tick(4);
        @(negedge clk);
        check("t2_full_ready", 32'(pc_ready_o), 32'd0);
        check("t2_head_valid", 32'(instr_valid_o), 32'd1);
        check("t2_head_pc", instr_pc_o, 32'h0);
        tick(3);
        fork
            send_pc(32'h8);
            begin
                tick(3);
                check("t2_still_blocked", 32'(pc_ready_o), 32'd0);
                instr_ready_i = 1'b1;
            end
        join
        tick(8);
        check("t2_drain", 32'(exp_q.size()), 32'd0);
        check("t2_empty", 32'(instr_valid_o), 32'd0);

        // 3: flush in RESP, response one cycle later
        rv_delay = 1;
        send_pc(32'h40);
        tick(1);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        tick(3);
        @(negedge clk);
        check("t3_dropped", 32'(instr_valid_o), 32'd0);
        tick(1);
        rv_delay = 0;
        send_pc(32'h100);
        tick(5);
        check("t3_drain", 32'(exp_q.size()), 32'd0);

        // 4: flush in REQ with gnt stalled 3 cycles
        gnt_stall = 3;
        req_cnt   = 0;
        send_pc(32'h80);
        flush_i = 1'b1;
        @(negedge clk);
        if (imem_req_o) req_cnt++;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req_o) req_cnt++;
        end
        check("t4_req_cycles", 32'(req_cnt), 32'd4);
        check("t4_discard", 32'(instr_valid_o), 32'd0);
        check("t4_ready", 32'(pc_ready_o), 32'd1);
        gnt_stall = 0;
        tick(1);

        // 5: misaligned pc
        instr_ready_i = 1'b0;
        send_pc(32'h2);
        @(negedge clk);
        check("t5_no_req", 32'(imem_req_o), 32'd0);
        check("t5_valid_c1", 32'(instr_valid_o), 32'd1);
        check("t5_instr", instr_o, 32'h00000013);
        check("t5_misal", 32'(instr_misal_o), 32'd1);
        check("t5_pc", instr_pc_o, 32'h2);
        tick(1);
        @(negedge clk);
        check("t5_no_req_later", 32'(imem_req_o), 32'd0);
        tick(1);
        instr_ready_i = 1'b1;
        tick(2);
        check("t5_drain", 32'(exp_q.size()), 32'd0);

        // 6: reset during RESP, stray rvalid afterwards
        instr_ready_i = 1'b0;
        rv_delay      = 3;
        send_pc(32'h6);
        send_pc(32'hC0);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(imem_req_o), 32'd0);
        check("t6_rst_addr", imem_addr_o, 32'd0);
        check("t6_rst_valid", 32'(instr_valid_o), 32'd0);
        check("t6_rst_instr", instr_o, 32'd0);
        check("t6_rst_pc", instr_pc_o, 32'd0);
        check("t6_rst_misal", 32'(instr_misal_o), 32'd0);
        tick(1);
        rst_n         = 1'b1;
        instr_ready_i = 1'b1;
        tick(8);
        check("t6_stray_ignored", 32'(instr_valid_o), 32'd0);
        check("t6_idle_ready", 32'(pc_ready_o), 32'd1);
        check("t6_no_req", 32'(imem_req_o), 32'd0);
        rv_delay = 0;
        send_pc(32'h200);
        tick(5);
        check("t6_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
